// File: rtl/color_meas_scheduler_if.sv
// Signal bundle between color_meas_scheduler, the board controls, the two
// colorlite sensors and the shared result bus.
interface color_meas_scheduler_if;
    logic        enable;
    logic        single_shot;
    logic        measure0;
    logic        measure1;
    logic        ready0;
    logic        ready1;
    logic [15:0] red0;
    logic [15:0] green0;
    logic [15:0] blue0;
    logic [15:0] red1;
    logic [15:0] green1;
    logic [15:0] blue1;
    logic        data_valid;
    logic        data_id;
    logic [15:0] data_r;
    logic [15:0] data_g;
    logic [15:0] data_b;
    logic [1:0]  timeout;
    logic        busy;

    modport master (
        input  enable, single_shot, ready0, ready1,
        input  red0, green0, blue0, red1, green1, blue1,
        output measure0, measure1, data_valid, data_id,
        output data_r, data_g, data_b, timeout, busy
    );

    modport slave (
        output enable, single_shot, ready0, ready1,
        output red0, green0, blue0, red1, green1, blue1,
        input  measure0, measure1, data_valid, data_id,
        input  data_r, data_g, data_b, timeout, busy
    );
endinterface

// File: rtl/color_meas_scheduler.sv
// Round scheduler for two colorlite sensors: sensor 0 then sensor 1, per tick or single shot.
// Optional per-sensor watchdog enabled by defining COLOR_SCHED_TIMEOUT_EN.
module color_meas_scheduler #(
    parameter int unsigned PERIOD_CYCLES  = 10_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                   clk,
    input  logic                   nrst,
    color_meas_scheduler_if.master bus
);

    if (PERIOD_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("color_meas_scheduler: PERIOD_CYCLES and TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_EMIT,
        S_NEXT
    } state_t;

    localparam int unsigned PW = $clog2(PERIOD_CYCLES);

    state_t      state;
    state_t      state_nx;
    logic        cur;
    logic        cur_nx;
    logic        pending;
    logic        pending_nx;
    logic        capture;
    logic        tick;
    logic        ready_cur;
    logic        to_hit;
    logic [PW-1:0] period_cnt;

    logic        data_id_q;
    logic [15:0] data_r_q;
    logic [15:0] data_g_q;
    logic [15:0] data_b_q;

    assign tick      = bus.enable && (period_cnt == PW'(PERIOD_CYCLES - 1));
    assign ready_cur = cur ? bus.ready1 : bus.ready0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            period_cnt <= '0;
        end else if (!bus.enable || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

`ifdef COLOR_SCHED_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);

    logic [WW-1:0] wd_cnt;
    logic          wd_expired;
    logic          waiting;
    logic [1:0]    timeout_q;

    assign waiting    = (state == S_WAIT_ACK) || (state == S_WAIT_DONE);
    assign wd_expired = (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
    // Only fires when the awaited ready edge is absent in the expiry cycle.
    assign to_hit     = wd_expired &&
                        (((state == S_WAIT_ACK) && ready_cur) ||
                         ((state == S_WAIT_DONE) && !ready_cur));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wd_cnt <= '0;
        end else if (state == S_TRIG) begin
            wd_cnt <= '0;
        end else if (waiting && !wd_expired) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            timeout_q <= '0;
        end else if (to_hit) begin
            timeout_q[cur] <= 1'b1;
        end else if (state == S_EMIT) begin
            timeout_q[cur] <= 1'b0;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign to_hit      = 1'b0;
    assign bus.timeout = 2'b00;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            cur     <= 1'b0;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            cur     <= cur_nx;
            pending <= pending_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cur_nx     = cur;
        pending_nx = pending | tick | bus.single_shot;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                // Requests arriving while the held one is consumed are dropped (depth 1).
                if (pending) begin
                    pending_nx = 1'b0;
                    cur_nx     = 1'b0;
                    state_nx   = S_TRIG;
                end
            end
            S_TRIG: begin
                state_nx = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!ready_cur) begin
                    state_nx = S_WAIT_DONE;
                end else if (to_hit) begin
                    state_nx = S_NEXT;
                end
            end
            S_WAIT_DONE: begin
                if (ready_cur) begin
                    capture  = 1'b1;
                    state_nx = S_EMIT;
                end else if (to_hit) begin
                    state_nx = S_NEXT;
                end
            end
            S_EMIT: begin
                state_nx = S_NEXT;
            end
            S_NEXT: begin
                if (!cur) begin
                    cur_nx   = 1'b1;
                    state_nx = S_TRIG;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Result is latched as EMIT is entered so data_* are stable for the whole strobe.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_id_q <= 1'b0;
            data_r_q  <= '0;
            data_g_q  <= '0;
            data_b_q  <= '0;
        end else if (capture) begin
            data_id_q <= cur;
            data_r_q  <= cur ? bus.red1   : bus.red0;
            data_g_q  <= cur ? bus.green1 : bus.green0;
            data_b_q  <= cur ? bus.blue1  : bus.blue0;
        end
    end

    assign bus.measure0   = (state == S_TRIG) && !cur;
    assign bus.measure1   = (state == S_TRIG) && cur;
    assign bus.data_valid = (state == S_EMIT);
    assign bus.data_id    = data_id_q;
    assign bus.data_r     = data_r_q;
    assign bus.data_g     = data_g_q;
    assign bus.data_b     = data_b_q;
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_color_meas_scheduler.sv
// Scoreboard bench for color_meas_scheduler with two behavioural colorlite sensor models.
module tb_color_meas_scheduler;
    localparam int unsigned PERIOD = 200;
    localparam int unsigned TMO    = 50;

    typedef struct packed {
        logic        id;
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
    } res_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    color_meas_scheduler_if bus ();

    color_meas_scheduler #(
        .PERIOD_CYCLES (PERIOD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    res_t exp_q[$];
    int   m0_times[$];
    int   high_delay[2];
    bit   never_drop[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [54:0] outs();
        return {bus.measure0, bus.measure1, bus.data_valid, bus.data_id,
                bus.data_r, bus.data_g, bus.data_b, bus.timeout, bus.busy};
    endfunction

    function automatic logic sel(input int which);
        case (which)
            0:       return bus.measure0;
            1:       return bus.measure1;
            2:       return bus.data_valid;
            default: return bus.busy;
        endcase
    endfunction

    task automatic wait_level(input int which, input logic val, input int limit, input string name);
        int n = 0;
        while (sel(which) !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sel(which) !== val) begin
            checks++;
            failures++;
            $display("FAIL %s wait expired after %0d cycles", name, n);
        end
    endtask

    task automatic set_colors(input logic [15:0] r0, g0, b0, r1, g1, b1);
        bus.red0 = r0; bus.green0 = g0; bus.blue0 = b0;
        bus.red1 = r1; bus.green1 = g1; bus.blue1 = b1;
    endtask

    task automatic push_round();
        exp_q.push_back({1'b0, bus.red0, bus.green0, bus.blue0});
        exp_q.push_back({1'b1, bus.red1, bus.green1, bus.blue1});
    endtask

    task automatic pulse_ss();
        bus.single_shot = 1'b1;
        @(negedge clk);
        bus.single_shot = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest expected result.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (bus.measure0 === 1'b1) m0_times.push_back(cyc);
            if (bus.data_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual id=%0d r=0x%0h required=none",
                             bus.data_id, bus.data_r);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe", {bus.data_id, bus.data_r, bus.data_g, bus.data_b}, e);
                end
            end
        end
    end

    // Sensor models: ready drops 3 cycles after measure, returns high_delay cycles later.
    initial begin
        int ph[2];
        int cnt[2];
        logic m;
        bus.ready0 = 1'b1;
        bus.ready1 = 1'b1;
        ph = '{0, 0};
        cnt = '{0, 0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                m = (i == 0) ? bus.measure0 : bus.measure1;
                if (m === 1'b1 && !never_drop[i]) begin
                    ph[i] = 1;
                    cnt[i] = 0;
                end else if (ph[i] == 1) begin
                    cnt[i]++;
                    if (cnt[i] == 3) begin
                        if (i == 0) bus.ready0 = 1'b0; else bus.ready1 = 1'b0;
                        ph[i] = 2;
                        cnt[i] = 0;
                    end
                end else if (ph[i] == 2) begin
                    cnt[i]++;
                    if (cnt[i] == high_delay[i]) begin
                        if (i == 0) bus.ready0 = 1'b1; else bus.ready1 = 1'b1;
                        ph[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int e;
        int base;
        int bz;
        high_delay = '{20, 20};
        never_drop = '{0, 0};
        bus.enable = 1'b0;
        bus.single_shot = 1'b0;
        set_colors(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Reset with random control/data inputs
        nrst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            bus.enable = 1'($urandom);
            bus.single_shot = 1'($urandom);
            set_colors(16'($urandom), 16'($urandom), 16'($urandom),
                       16'($urandom), 16'($urandom), 16'($urandom));
            #1;
            check("reset_outputs", 64'(outs()), 64'd0);
        end
        @(negedge clk);
        bus.enable = 1'b0;
        bus.single_shot = 1'b0;
        nrst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_reset_idle", 64'(outs()), 64'd0);
        end

        // Single round
        set_colors(16'h1234, 16'h5678, 16'h9ABC, 16'h0001, 16'h0002, 16'h0003);
        push_round();
        pulse_ss();
        check("measure0_not_at_n1", 64'(bus.measure0), 64'd0);
        check("busy_low_at_n1", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("measure0_at_n2", 64'(bus.measure0), 64'd1);
        @(negedge clk);
        check("measure0_one_cycle", 64'(bus.measure0), 64'd0);
        wait_level(2, 1'b1, 100, "emit0");
        @(negedge clk);
        check("measure1_not_at_emit1", 64'(bus.measure1), 64'd0);
        @(negedge clk);
        check("measure1_emit_plus2", 64'(bus.measure1), 64'd1);
        wait_level(2, 1'b1, 100, "emit1");
        @(negedge clk);
        check("busy_in_next", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check("busy_falls_after_next", 64'(bus.busy), 64'd0);
        check("data_hold_r", 64'(bus.data_r), 64'h0001);

        // Depth-1 pending: two extra requests during a round give one more round
        repeat (3) @(negedge clk);
        base = m0_times.size();
        push_round();
        push_round();
        pulse_ss();
        repeat (5) @(negedge clk);
        pulse_ss();
        repeat (3) @(negedge clk);
        pulse_ss();
        repeat (200) @(negedge clk);
        check("depth1_rounds", 64'(m0_times.size() - base), 64'd2);
        check("depth1_sb_drained", 64'(exp_q.size()), 64'd0);

        // Periodic mode for 1000 cycles
        set_colors(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h1111, 16'h2222, 16'h3333);
        repeat (5) push_round();
        m0_times.delete();
        @(negedge clk);
        bus.enable = 1'b1;
        e = cyc;
        repeat (1000) @(negedge clk);
        bus.enable = 1'b0;
        repeat (150) @(negedge clk);
        check("periodic_sb_drained", 64'(exp_q.size()), 64'd0);
        check("periodic_rounds", 64'(m0_times.size()), 64'd5);
        for (int k = 0; k < 5 && k < m0_times.size(); k++)
            check($sformatf("periodic_start_%0d", k), 64'(m0_times[k] - e), 64'(201 + 200 * k));
        repeat (300) @(negedge clk);
        check("no_tick_after_disable", 64'(m0_times.size()), 64'd5);

`ifndef COLOR_SCHED_TIMEOUT_EN
        // Overrun: sensor 1 takes longer than a period
        high_delay[1] = 250;
        set_colors(16'h0F0F, 16'hF0F0, 16'h5A5A, 16'hA5A5, 16'h3C3C, 16'hC3C3);
        push_round();
        push_round();
        base = m0_times.size();
        @(negedge clk);
        bus.enable = 1'b1;
        e = cyc;
        wait_level(0, 1'b1, 400, "overrun_first_measure0");
        check("overrun_first_start", 64'(cyc - e), 64'd201);
        @(negedge clk);
        wait_level(3, 1'b0, 600, "overrun_idle");
        check("overrun_idle_reentry", 64'(cyc - e), 64'd483);
        @(negedge clk);
        check("overrun_restart_next_cycle", 64'(bus.measure0), 64'd1);
        bus.enable = 1'b0;
        @(negedge clk);
        wait_level(3, 1'b0, 600, "overrun_round2_done");
        repeat (300) @(negedge clk);
        check("overrun_rounds", 64'(m0_times.size() - base), 64'd2);
        check("overrun_sb_drained", 64'(exp_q.size()), 64'd0);
        check("timeout_tied_low", 64'(bus.timeout), 64'd0);
        high_delay[1] = 20;
`else
        // Watchdog: sensor 0 never acknowledges
        never_drop[0] = 1'b1;
        set_colors(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h0102, 16'h0304, 16'h0506);
        exp_q.push_back({1'b1, 16'h0102, 16'h0304, 16'h0506});
        pulse_ss();
        repeat (51) @(negedge clk);
        check("timeout_not_yet", 64'(bus.timeout), 64'd0);
        @(negedge clk);
        check("timeout_bit0_set", 64'(bus.timeout), 64'd1);
        @(negedge clk);
        check("timeout_then_measure1", 64'(bus.measure1), 64'd1);
        wait_level(3, 1'b0, 200, "timeout_round_done");
        repeat (5) @(negedge clk);
        check("timeout_sticky", 64'(bus.timeout), 64'd1);
        check("timeout_sb_drained", 64'(exp_q.size()), 64'd0);
        never_drop[0] = 1'b0;
        push_round();
        pulse_ss();
        @(negedge clk);
        wait_level(3, 1'b0, 200, "recover_round_done");
        @(negedge clk);
        check("timeout_cleared", 64'(bus.timeout), 64'd0);
        check("recover_sb_drained", 64'(exp_q.size()), 64'd0);
`endif

        // Mid-round reset during WAIT_DONE of sensor 0
        set_colors(16'h7777, 16'h8888, 16'h9999, 16'h4444, 16'h5555, 16'h6666);
        repeat (5) @(negedge clk);
        pulse_ss();
        repeat (9) @(negedge clk);
        check("busy_before_reset", 64'(bus.busy), 64'd1);
        nrst = 1'b0;
        #1;
        check("mid_reset_outputs", 64'(outs()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        base = m0_times.size();
        bz = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus.busy === 1'b1) bz++;
        end
        check("no_activity_after_release", 64'(bz), 64'd0);
        check("no_retrigger_after_release", 64'(m0_times.size() - base), 64'd0);
        check("final_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
